// File: rtl/datapath_pkg.sv
// Shared types for the execution datapath: ALU operation encodings.
package datapath_pkg;

   localparam int ALU_SEL_W = 4;

   typedef enum logic [ALU_SEL_W-1:0] {
      ALU_PASS_A = 4'd0,
      ALU_ADD    = 4'd1,
      ALU_SUB    = 4'd2,
      ALU_AND    = 4'd3,
      ALU_OR     = 4'd4,
      ALU_XOR    = 4'd5,
      ALU_NOT_A  = 4'd6,
      ALU_SHL1_A = 4'd7,
      ALU_SHR1_A = 4'd8,
      ALU_INC_A  = 4'd9,
      ALU_DEC_A  = 4'd10
   } alu_op_e;

endpackage

// File: rtl/datapath_unit_register_file.sv
// Two-read/one-write register file; reads are combinational and return the
// pre-write contents on a same-cycle collision.
module register_file #(
   parameter int WIDTH    = 16,
   parameter int R_ADDR_W = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                w_en,
   input  logic [R_ADDR_W-1:0] w_addr,
   input  logic [WIDTH-1:0]    w_data,
   input  logic [R_ADDR_W-1:0] a_addr,
   input  logic [R_ADDR_W-1:0] b_addr,
   output logic [WIDTH-1:0]    a_data,
   output logic [WIDTH-1:0]    b_data
);

   localparam int unsigned DEPTH = 2 ** R_ADDR_W;

   logic [WIDTH-1:0] regs_q [DEPTH];
   logic [WIDTH-1:0] regs_d [DEPTH];

   always_comb begin
      regs_d = regs_q;
      if (w_en) regs_d[w_addr] = w_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   assign a_data = regs_q[a_addr];
   assign b_data = regs_q[b_addr];

endmodule

// File: rtl/datapath_unit.sv
// Execution datapath: register file, inline ALU and synchronous data memory.
// Optional registered Z/N flags when DATAPATH_FLAGS_EN is defined.
module datapath_unit
   import datapath_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int D_ADDR_W = 8,
   parameter int R_ADDR_W = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 D_wr,
   input  logic                 RF_s,
   input  logic                 RF_W_en,
   input  logic [D_ADDR_W-1:0]  D_addr,
   input  logic [R_ADDR_W-1:0]  RF_W_addr,
   input  logic [R_ADDR_W-1:0]  RF_A_addr,
   input  logic [R_ADDR_W-1:0]  RF_B_addr,
   input  logic [ALU_SEL_W-1:0] ALU_sel,
   output logic [WIDTH-1:0]     ALU_A_out,
   output logic [WIDTH-1:0]     ALU_B_out,
   output logic [WIDTH-1:0]     ALU_out,
`ifdef DATAPATH_FLAGS_EN
   output logic                 Z_flag,
   output logic                 N_flag,
`endif
   output logic [WIDTH-1:0]     Mem_out
);

   localparam int unsigned MEM_DEPTH = 2 ** D_ADDR_W;

   logic [WIDTH-1:0] rf_w_data;
   logic [WIDTH-1:0] mem_out_q, mem_out_d;
   logic [WIDTH-1:0] mem_q [MEM_DEPTH];
   alu_op_e          alu_op;

   register_file #(
      .WIDTH    (WIDTH),
      .R_ADDR_W (R_ADDR_W)
   ) u_rf (
      .clk    (clk),
      .rst    (reset),
      .w_en   (RF_W_en),
      .w_addr (RF_W_addr),
      .w_data (rf_w_data),
      .a_addr (RF_A_addr),
      .b_addr (RF_B_addr),
      .a_data (ALU_A_out),
      .b_data (ALU_B_out)
   );

   always_comb begin
      alu_op  = alu_op_e'(ALU_sel);
      ALU_out = '0;
      case (alu_op)
         ALU_PASS_A: ALU_out = ALU_A_out;
         ALU_ADD:    ALU_out = ALU_A_out + ALU_B_out;
         ALU_SUB:    ALU_out = ALU_A_out - ALU_B_out;
         ALU_AND:    ALU_out = ALU_A_out & ALU_B_out;
         ALU_OR:     ALU_out = ALU_A_out | ALU_B_out;
         ALU_XOR:    ALU_out = ALU_A_out ^ ALU_B_out;
         ALU_NOT_A:  ALU_out = ~ALU_A_out;
         ALU_SHL1_A: ALU_out = {ALU_A_out[WIDTH-2:0], 1'b0};
         ALU_SHR1_A: ALU_out = {1'b0, ALU_A_out[WIDTH-1:1]};
         ALU_INC_A:  ALU_out = ALU_A_out + WIDTH'(1);
         ALU_DEC_A:  ALU_out = ALU_A_out - WIDTH'(1);
         default:    ALU_out = '0;
      endcase
   end

   assign rf_w_data = RF_s ? mem_out_q : ALU_out;

   // Memory contents survive reset; only the write is blocked while reset is high.
   always_ff @(posedge clk) begin
      if (D_wr && !reset) mem_q[D_addr] <= ALU_A_out;
   end

   always_comb mem_out_d = mem_q[D_addr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) mem_out_q <= '0;
      else       mem_out_q <= mem_out_d;
   end

   assign Mem_out = mem_out_q;

`ifdef DATAPATH_FLAGS_EN
   logic z_q, z_d, n_q, n_d;

   always_comb begin
      z_d = z_q;
      n_d = n_q;
      if (RF_W_en && !RF_s) begin
         z_d = (ALU_out == '0);
         n_d = ALU_out[WIDTH-1];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         z_q <= 1'b0;
         n_q <= 1'b0;
      end else begin
         z_q <= z_d;
         n_q <= n_d;
      end
   end

   assign Z_flag = z_q;
   assign N_flag = n_q;
`endif

endmodule

// File: tb/tb_datapath_unit.sv
// Self-checking bench for datapath_unit: reference model plus Mem_out scoreboard.
module tb_datapath_unit;
   import datapath_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        D_wr, RF_s, RF_W_en;
   logic [7:0]  D_addr;
   logic [3:0]  RF_W_addr, RF_A_addr, RF_B_addr, ALU_sel;
   logic [15:0] ALU_A_out, ALU_B_out, ALU_out, Mem_out;
`ifdef DATAPATH_FLAGS_EN
   logic        Z_flag, N_flag;
`endif

   datapath_unit dut (
      .clk       (clk),
      .reset     (reset),
      .D_wr      (D_wr),
      .RF_s      (RF_s),
      .RF_W_en   (RF_W_en),
      .D_addr    (D_addr),
      .RF_W_addr (RF_W_addr),
      .RF_A_addr (RF_A_addr),
      .RF_B_addr (RF_B_addr),
      .ALU_sel   (ALU_sel),
      .ALU_A_out (ALU_A_out),
      .ALU_B_out (ALU_B_out),
      .ALU_out   (ALU_out),
`ifdef DATAPATH_FLAGS_EN
      .Z_flag    (Z_flag),
      .N_flag    (N_flag),
`endif
      .Mem_out   (Mem_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        known;
      logic [15:0] val;
   } sb_t;

   typedef struct {
      logic [3:0]  sel, a, b, w;
      logic [15:0] exp;
   } alu_vec_t;

   sb_t         sb_q[$];
   logic [15:0] rf_m [16];
   logic [15:0] mem_m [256];
   bit          mem_k [256];
   logic [15:0] mem_out_m;
   logic        z_m, n_m;
   int          n_pass = 0;
   int          n_total = 0;

   function automatic logic [15:0] alu_m(input int sel, input logic [15:0] a, input logic [15:0] b);
      int unsigned r;
      int unsigned ua = 32'(a);
      int unsigned ub = 32'(b);
      case (sel)
         0:  r = ua;
         1:  r = ua + ub;
         2:  r = ua - ub;
         3:  r = ua & ub;
         4:  r = ua | ub;
         5:  r = ua ^ ub;
         6:  r = 32'hFFFF ^ ua;
         7:  r = ua * 2;
         8:  r = ua / 2;
         9:  r = ua + 1;
         10: r = ua - 1;
         default: r = 0;
      endcase
      return r[15:0];
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      else n_pass++;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) rf_m[i] = '0;
      mem_out_m = '0;
      z_m = 1'b0;
      n_m = 1'b0;
   endtask

   // One control word per clock; entered and left at posedge+1.
   task automatic step(input logic dwr, input logic rfs, input logic wen, input logic [7:0] da,
                       input logic [3:0] w, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] sel, output logic [15:0] a_b, output logic [15:0] y_b);
      logic [15:0] alu_v, wdata, st_a;
      sb_t         e;
      D_wr = dwr; RF_s = rfs; RF_W_en = wen; D_addr = da;
      RF_W_addr = w; RF_A_addr = a; RF_B_addr = b; ALU_sel = sel;
      #1;
      alu_v = alu_m(int'(sel), rf_m[a], rf_m[b]);
      check("rd_a", ALU_A_out, rf_m[a]);
      check("rd_b", ALU_B_out, rf_m[b]);
      check("alu", ALU_out, alu_v);
      a_b   = ALU_A_out;
      y_b   = ALU_out;
      wdata = rfs ? mem_out_m : alu_v;
      st_a  = rf_m[a];
      sb_q.push_back('{known: mem_k[da], val: mem_m[da]});
      @(posedge clk);
      #1;
      if (wen) rf_m[w] = wdata;
      if (dwr) begin
         mem_m[da] = st_a;
         mem_k[da] = 1'b1;
      end
      if (wen && !rfs) begin
         z_m = (alu_v == 16'h0);
         n_m = alu_v[15];
      end
      e = sb_q.pop_front();
      mem_out_m = e.val;
      if (e.known) check("mem_out", Mem_out, e.val);
`ifdef DATAPATH_FLAGS_EN
      check("z_flag", {15'b0, Z_flag}, {15'b0, z_m});
      check("n_flag", {15'b0, N_flag}, {15'b0, n_m});
`endif
   endtask

   task automatic load_const(input logic [3:0] r, input logic [15:0] v);
      logic [15:0] ab, yb;
      step(0, 0, 1, 8'h00, r, 4'd0, 4'd0, ALU_PASS_A, ab, yb);
      for (int i = 15; i >= 0; i--) begin
         step(0, 0, 1, 8'h00, r, r, 4'd0, ALU_SHL1_A, ab, yb);
         if (v[i]) step(0, 0, 1, 8'h00, r, r, 4'd0, ALU_INC_A, ab, yb);
      end
   endtask

   alu_vec_t    vt [13];
   logic [15:0] rst_exp [16];
   logic [15:0] ab, yb;

   initial begin
      vt[0]  = '{sel: ALU_ADD,    a: 4'd1, b: 4'd2, w: 4'd4,  exp: 16'h0000};
      vt[1]  = '{sel: ALU_SUB,    a: 4'd2, b: 4'd1, w: 4'd4,  exp: 16'h0002};
      vt[2]  = '{sel: ALU_SHR1_A, a: 4'd6, b: 4'd0, w: 4'd10, exp: 16'h4000};
      vt[3]  = '{sel: ALU_AND,    a: 4'd1, b: 4'd2, w: 4'd4,  exp: 16'h0001};
      vt[4]  = '{sel: ALU_OR,     a: 4'd2, b: 4'd6, w: 4'd10, exp: 16'h8001};
      vt[5]  = '{sel: ALU_XOR,    a: 4'd1, b: 4'd6, w: 4'd4,  exp: 16'h7FFE};
      vt[6]  = '{sel: ALU_NOT_A,  a: 4'd6, b: 4'd0, w: 4'd10, exp: 16'h7FFE};
      vt[7]  = '{sel: ALU_SHL1_A, a: 4'd6, b: 4'd0, w: 4'd4,  exp: 16'h0002};
      vt[8]  = '{sel: ALU_INC_A,  a: 4'd1, b: 4'd0, w: 4'd10, exp: 16'h0000};
      vt[9]  = '{sel: ALU_DEC_A,  a: 4'd0, b: 4'd0, w: 4'd4,  exp: 16'hFFFF};
      vt[10] = '{sel: ALU_SUB,    a: 4'd0, b: 4'd2, w: 4'd10, exp: 16'hFFFF};
      vt[11] = '{sel: ALU_PASS_A, a: 4'd6, b: 4'd1, w: 4'd4,  exp: 16'h8001};
      vt[12] = '{sel: 4'd13,      a: 4'd1, b: 4'd1, w: 4'd10, exp: 16'h0000};
      for (int s = 0; s < 16; s++) rst_exp[s] = 16'h0000;
      rst_exp[6]  = 16'hFFFF;
      rst_exp[9]  = 16'h0001;
      rst_exp[10] = 16'hFFFF;

      reset = 1'b1; D_wr = 1'b0; RF_s = 1'b0; RF_W_en = 1'b0; D_addr = '0;
      RF_W_addr = '0; RF_A_addr = '0; RF_B_addr = '0; ALU_sel = '0;
      model_reset();
      #1;
      check("init_a", ALU_A_out, 16'h0000);
      check("init_mem", Mem_out, 16'h0000);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // ALU vectors on R1=FFFF, R2=0001, R6=8001
      load_const(4'd1, 16'hFFFF);
      load_const(4'd2, 16'h0001);
      load_const(4'd6, 16'h8001);
      for (int i = 0; i < 13; i++) begin
         step(0, 0, 1, 8'h00, vt[i].w, vt[i].a, vt[i].b, vt[i].sel, ab, yb);
         check($sformatf("vec%0d", i), yb, vt[i].exp);
      end

      // Load path, including RF capture of the previous Mem_out
      load_const(4'd1, 16'h1234);
      step(1, 0, 0, 8'h11, 4'd0, 4'd6, 4'd0, ALU_PASS_A, ab, yb);
      step(1, 0, 0, 8'h10, 4'd0, 4'd1, 4'd0, ALU_PASS_A, ab, yb);
      step(0, 0, 0, 8'h11, 4'd0, 4'd0, 4'd0, ALU_PASS_A, ab, yb);
      check("ld_prev", Mem_out, 16'h8001);
      step(0, 1, 1, 8'h10, 4'd11, 4'd0, 4'd0, ALU_PASS_A, ab, yb);
      check("ld_mem", Mem_out, 16'h1234);
      step(0, 1, 1, 8'h10, 4'd3, 4'd0, 4'd0, ALU_PASS_A, ab, yb);
      step(0, 0, 0, 8'h10, 4'd0, 4'd3, 4'd11, ALU_PASS_A, ab, yb);
      check("ld_r3", ALU_A_out, 16'h1234);
      check("ld_r11_old", ALU_B_out, 16'h8001);

      // Store with same-cycle read of the same address
      load_const(4'd1, 16'hABCD);
      step(1, 0, 0, 8'd20, 4'd0, 4'd6, 4'd0, ALU_PASS_A, ab, yb);
      step(1, 0, 0, 8'd20, 4'd0, 4'd1, 4'd0, ALU_PASS_A, ab, yb);
      check("st_old", Mem_out, 16'h8001);
      step(0, 0, 0, 8'd20, 4'd0, 4'd0, 4'd0, ALU_PASS_A, ab, yb);
      check("st_new", Mem_out, 16'hABCD);
      step(1, 0, 0, 8'd5, 4'd0, 4'd1, 4'd0, ALU_PASS_A, ab, yb);

      // Read-during-write on RF returns the old value
      load_const(4'd5, 16'h0054);
      step(0, 0, 1, 8'd5, 4'd5, 4'd5, 4'd0, ALU_INC_A, ab, yb);
      check("rdw_old", ab, 16'h0054);
      check("rdw_new", ALU_A_out, 16'h0055);

`ifdef DATAPATH_FLAGS_EN
      step(0, 0, 1, 8'h10, 4'd8, 4'd1, 4'd1, ALU_SUB, ab, yb);
      check("z_sub", {15'b0, Z_flag}, 16'd1);
      check("n_sub", {15'b0, N_flag}, 16'd0);
      step(0, 0, 1, 8'h10, 4'd8, 4'd0, 4'd0, ALU_DEC_A, ab, yb);
      check("z_dec", {15'b0, Z_flag}, 16'd0);
      check("n_dec", {15'b0, N_flag}, 16'd1);
      step(0, 1, 1, 8'h10, 4'd8, 4'd0, 4'd0, ALU_PASS_A, ab, yb);
      check("z_load", {15'b0, Z_flag}, 16'd0);
      check("n_load", {15'b0, N_flag}, 16'd1);
`endif

      // Asynchronous reset mid-cycle with store and RF write pending
      D_wr = 1'b1; RF_s = 1'b0; RF_W_en = 1'b1; D_addr = 8'd5;
      RF_W_addr = 4'd9; RF_A_addr = 4'd1; RF_B_addr = 4'd5; ALU_sel = ALU_INC_A;
      #2;
      reset = 1'b1;
      #1;
      check("rst_a_now", ALU_A_out, 16'h0000);
      check("rst_b_now", ALU_B_out, 16'h0000);
      check("rst_mem_now", Mem_out, 16'h0000);
      for (int i = 0; i < 16; i++) begin
         RF_A_addr = 4'(i);
         RF_B_addr = 4'(15 - i);
         #1;
         check($sformatf("rst_rf_a%0d", i), ALU_A_out, 16'h0000);
         check($sformatf("rst_rf_b%0d", i), ALU_B_out, 16'h0000);
      end
      RF_A_addr = 4'd1;
      RF_B_addr = 4'd2;
      for (int s = 0; s < 16; s++) begin
         ALU_sel = 4'(s);
         #1;
         check($sformatf("rst_f00_%0d", s), ALU_out, rst_exp[s]);
      end
      @(posedge clk);
      #1;
      check("rst_mem_hold", Mem_out, 16'h0000);
      D_wr = 1'b0;
      RF_W_en = 1'b0;
      reset = 1'b0;
      model_reset();
      step(0, 0, 0, 8'd5, 4'd0, 4'd9, 4'd1, ALU_PASS_A, ab, yb);
      check("rst_mem5", Mem_out, 16'hABCD);
      check("rst_r9", ab, 16'h0000);
`ifdef DATAPATH_FLAGS_EN
      check("rst_z", {15'b0, Z_flag}, 16'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
